// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the byte-wide asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // bus_size encodings; 2'd3 is handled as a word everywhere.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Number of byte-wide SRAM cycles a bus access needs.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Halves must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Femto-bus to 8-bit asynchronous SRAM sequencer. Each bus access is split
// into byte cycles of SETUP / STROBE (WAIT_CYC cycles) / HOLD, followed by a
// single DONE cycle that pulses bus_resp.
//
// Bus handshake: the requester raises bus_req with stable fields and holds it
// until it sees bus_resp; fields are latched on the accepting edge (IDLE only),
// and bus_resp is a one-cycle pulse with bus_rdata/bus_err valid alongside it.
//
// Every output is a flop. The combinational block computes the values the
// outputs must show in the *next* state, so strobes are glitch-free.
module sram_ctrl #(
  parameter int WAIT_CYC = 1,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [1:0]        bus_size,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_resp,
  output logic              bus_err,
  output logic              sram_ce_bar,
  output logic              sram_oe_bar,
  output logic              sram_we_bar,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_doe,
  input  logic [7:0]        sram_din
);
  import sram_ctrl_pkg::*;

  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("sram_ctrl: WAIT_CYC must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  // Sequencing state and the request latched at the accept edge.
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         acc_q, acc_d;

  // Registered outputs.
  logic                ce_bar_q, ce_bar_d;
  logic                oe_bar_q, oe_bar_d;
  logic                we_bar_q, we_bar_d;
  logic                doe_q, doe_d;
  logic [ADDR_W-1:0]   saddr_q, saddr_d;
  logic [7:0]          dout_q, dout_d;
  logic                resp_q, resp_d;
  logic                berr_q, berr_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [1:0]          idx_nx;
  logic                last_byte;

  assign idx_nx    = idx_q + 2'd1;
  assign last_byte = ({1'b0, idx_q} == (byte_count(size_q) - 3'd1));

  // Next-state and next-output logic; outputs default to the idle pattern.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    acc_d    = acc_q;
    ce_bar_d = 1'b1;
    oe_bar_d = 1'b1;
    we_bar_d = 1'b1;
    doe_d    = 1'b0;
    saddr_d  = saddr_q;
    dout_d   = dout_q;
    resp_d   = 1'b0;
    berr_d   = 1'b0;
    rdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          we_d    = bus_we;
          size_d  = bus_size;
          addr_d  = bus_addr;
          wdata_d = bus_wdata;
          err_d   = is_misaligned(bus_size, bus_addr[1:0]);
          idx_d   = 2'd0;
          acc_d   = '0;
          state_d = ST_SETUP;
          // A misaligned request still spends one quiet cycle in SETUP so
          // its error response lands one edge after the accept edge.
          if (!is_misaligned(bus_size, bus_addr[1:0])) begin
            ce_bar_d = 1'b0;
            saddr_d  = bus_addr;
            if (bus_we) begin
              doe_d  = 1'b1;
              dout_d = bus_wdata[7:0];
            end
          end
        end
      end

      ST_SETUP: begin
        if (err_q) begin
          state_d = ST_DONE;
          resp_d  = 1'b1;
          berr_d  = 1'b1;
        end else begin
          state_d  = ST_STROBE;
          cnt_d    = CNT_INIT;
          ce_bar_d = 1'b0;
          doe_d    = we_q;
          if (we_q) we_bar_d = 1'b0;
          else      oe_bar_d = 1'b0;
        end
      end

      ST_STROBE: begin
        ce_bar_d = 1'b0;
        doe_d    = we_q;
        if (cnt_q == 4'd0) begin
          // This edge ends the strobe: read data is sampled here.
          state_d = ST_HOLD;
          if (!we_q) acc_d[{idx_q, 3'b000} +: 8] = sram_din;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (we_q) we_bar_d = 1'b0;
          else      oe_bar_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (last_byte) begin
          state_d = ST_DONE;
          resp_d  = 1'b1;
          rdata_d = acc_q;
        end else begin
          state_d  = ST_SETUP;
          idx_d    = idx_nx;
          ce_bar_d = 1'b0;
          saddr_d  = addr_q + ADDR_W'(idx_nx);
          doe_d    = we_q;
          if (we_q) dout_d = wdata_q[{idx_nx, 3'b000} +: 8];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  // Output registers; reset forces strobes inactive and the pad undriven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_bar_q <= 1'b1;
      oe_bar_q <= 1'b1;
      we_bar_q <= 1'b1;
      doe_q    <= 1'b0;
      saddr_q  <= '0;
      dout_q   <= '0;
      resp_q   <= 1'b0;
      berr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ce_bar_q <= ce_bar_d;
      oe_bar_q <= oe_bar_d;
      we_bar_q <= we_bar_d;
      doe_q    <= doe_d;
      saddr_q  <= saddr_d;
      dout_q   <= dout_d;
      resp_q   <= resp_d;
      berr_q   <= berr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign sram_ce_bar = ce_bar_q;
  assign sram_oe_bar = oe_bar_q;
  assign sram_we_bar = we_bar_q;
  assign sram_doe    = doe_q;
  assign sram_addr   = saddr_q;
  assign sram_dout   = dout_q;
  assign bus_resp    = resp_q;
  assign bus_err     = berr_q;
  assign bus_rdata   = rdata_q;

endmodule
